// File: rtl/reuse_ptr_ctrl_pkg.sv
// Shared types and sizing constants for the line-reuse pointer sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reuse_pkg;

    localparam int PTR_W   = 9;
    localparam int CNT_W   = 8;
    localparam int MIN_COL = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RIGHT = 3'd1,
        S_TURN  = 3'd2,
        S_LEFT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/reuse_ptr_ctrl_if.sv
// Control/pointer bundle between the scan requester and reuse_ptr_ctrl; stall_cnt exists only with REUSE_PTR_CTRL_PERF_EN.
// Latency: n/a (wiring only).
// Backpressure: hold travels master->slave and freezes the scan.
interface reuse_ptr_ctrl_if #(
    parameter int PTR_W = reuse_pkg::PTR_W,
    parameter int CNT_W = reuse_pkg::CNT_W
);
    logic             start;
    logic [PTR_W-1:0] col;
    logic             hold;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             ptr_valid;
    logic             dir;
    logic             first_row;
    logic [CNT_W-1:0] row_cnt;
    logic             busy;
    logic             done;
    logic             cfg_err;
`ifdef REUSE_PTR_CTRL_PERF_EN
    logic [15:0]      stall_cnt;
`endif

    modport master (
        output start, col, hold,
        input  rd_ptr, wr_ptr, ptr_valid, dir, first_row, row_cnt, busy, done, cfg_err
`ifdef REUSE_PTR_CTRL_PERF_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  start, col, hold,
        output rd_ptr, wr_ptr, ptr_valid, dir, first_row, row_cnt, busy, done, cfg_err
`ifdef REUSE_PTR_CTRL_PERF_EN
        , output stall_cnt
`endif
    );

endinterface

// File: rtl/reuse_ptr_ctrl_updown_cnt.sv
// Loadable up/down counter with enable, flagging zero and a programmable last value.
// Latency: count updates one cycle after load/en; flags are combinational on the count.
// Backpressure: none; en low holds the count.
module reuse_updown_cnt #(
    parameter int W = reuse_pkg::PTR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         at_zero,
    output logic         at_last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= up ? cnt + W'(1) : cnt - W'(1);
        end
    end

    assign at_zero = (cnt == '0);
    assign at_last = (cnt == last);

endmodule

// File: rtl/reuse_ptr_ctrl.sv
// Serpentine 3x3-valid scan sequencer driving the shared rd/wr pointer of the line-reuse arrays (REUSE_PTR_CTRL_PERF_EN adds stall_cnt).
// Latency: first valid pointer the cycle after an accepted start; R*P + R busy cycles per scan.
// Backpressure: hold freezes RIGHT/LEFT/TURN and masks ptr_valid; ignored in IDLE and DONE.
module reuse_ptr_ctrl #(
    parameter int PTR_W   = reuse_pkg::PTR_W,
    parameter int CNT_W   = reuse_pkg::CNT_W,
    parameter int MIN_COL = reuse_pkg::MIN_COL
) (
    input  logic            clk,
    input  logic            rst_n,
    reuse_ptr_ctrl_if.slave bus
);
    import reuse_pkg::*;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] w_q, w_d;
    logic [PTR_W-1:0] last_ptr;
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] last_row;
    logic             dir_q, dir_d;
    logic             first_q, first_d;
    logic             cfg_err_q, cfg_err_d;
    logic             start_ok;
    logic             ld, en, up;
    logic             at_zero, at_last;

    // Square map: positions per row and row count are both w-2, so one "last" serves both.
    assign last_ptr = w_q - PTR_W'(3);
    assign last_row = CNT_W'(last_ptr);
    assign start_ok = (state_q == S_IDLE) && bus.start && (bus.col >= PTR_W'(MIN_COL));

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        row_d     = row_q;
        dir_d     = dir_q;
        first_d   = first_q;
        cfg_err_d = 1'b0;
        ld        = 1'b0;
        en        = 1'b0;
        up        = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    w_d     = bus.col;
                    state_d = S_RIGHT;
                    ld      = 1'b1;
                    row_d   = '0;
                    dir_d   = 1'b0;
                    first_d = 1'b1;
                end else if (bus.start) begin
                    cfg_err_d = 1'b1;
                end
            end
            S_RIGHT: begin
                if (!bus.hold) begin
                    if (!at_last)              en      = 1'b1;
                    else if (row_q == last_row) state_d = S_DONE;
                    else                        state_d = S_TURN;
                end
            end
            S_LEFT: begin
                if (!bus.hold) begin
                    up = 1'b0;
                    if (!at_zero)              en      = 1'b1;
                    else if (row_q == last_row) state_d = S_DONE;
                    else                        state_d = S_TURN;
                end
            end
            S_TURN: begin
                // Pointer stays put: the new row starts at the column where the old one ended.
                if (!bus.hold) begin
                    row_d   = row_q + CNT_W'(1);
                    dir_d   = ~dir_q;
                    first_d = 1'b0;
                    state_d = dir_q ? S_RIGHT : S_LEFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ld      = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            w_q       <= '0;
            row_q     <= '0;
            dir_q     <= 1'b0;
            first_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            row_q     <= row_d;
            dir_q     <= dir_d;
            first_q   <= first_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    reuse_updown_cnt #(.W(PTR_W)) u_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ld),
        .load_val ('0),
        .en       (en),
        .up       (up),
        .last     (last_ptr),
        .cnt      (ptr),
        .at_zero  (at_zero),
        .at_last  (at_last)
    );

    assign bus.rd_ptr    = ptr;
    assign bus.wr_ptr    = ptr;
    assign bus.ptr_valid = ((state_q == S_RIGHT) || (state_q == S_LEFT)) && !bus.hold;
    assign bus.dir       = dir_q;
    assign bus.first_row = first_q;
    assign bus.row_cnt   = row_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.cfg_err   = cfg_err_q;

`ifdef REUSE_PTR_CTRL_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if (bus.busy && bus.hold && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_reuse_ptr_ctrl.sv
// Scoreboard bench for reuse_ptr_ctrl: stimulus queues expected pointer beats, done and cfg_err pulses;
// a negedge monitor pops and compares whenever the DUT presents one of them.
module tb_reuse_ptr_ctrl;
    import reuse_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reuse_ptr_ctrl_if bus ();

    reuse_ptr_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // kind = {ptr_valid, done, cfg_err}
    typedef struct {
        logic [2:0] kind;
        int         ptr;
        bit         dir;
        bit         first;
        int         row;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_v(input int p, input int r);
        exp_t e;
        e.kind  = 3'b100;
        e.ptr   = p;
        e.dir   = r[0];
        e.first = (r == 0);
        e.row   = r;
        q.push_back(e);
    endtask

    task automatic push_k(input logic [2:0] k);
        exp_t e;
        e.kind  = k;
        e.ptr   = 0;
        e.dir   = 1'b0;
        e.first = 1'b0;
        e.row   = 0;
        q.push_back(e);
    endtask

    task automatic gen_scan(input int w);
        int n;
        n = w - 2;
        for (int r = 0; r < n; r++)
            for (int i = 0; i < n; i++)
                push_v((r % 2 == 0) ? i : n - 1 - i, r);
        push_k(3'b010);
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.ptr_valid || bus.done || bus.cfg_err)) begin
            if (q.size() == 0) begin
                chk("unexpected_out", {29'd0, bus.ptr_valid, bus.done, bus.cfg_err}, 32'd0);
            end else begin
                mon_e = q.pop_front();
                chk("out_kind", {29'd0, bus.ptr_valid, bus.done, bus.cfg_err}, {29'd0, mon_e.kind});
                if (bus.ptr_valid) begin
                    chk("rd_ptr", 32'(bus.rd_ptr), mon_e.ptr);
                    chk("wr_ptr", 32'(bus.wr_ptr), mon_e.ptr);
                    chk("dir", {31'd0, bus.dir}, {31'd0, mon_e.dir});
                    chk("first_row", {31'd0, bus.first_row}, {31'd0, mon_e.first});
                    chk("row_cnt", 32'(bus.row_cnt), mon_e.row);
                end
            end
        end
    end

    task automatic chk_all_zero(input string nm);
        chk(nm, {bus.rd_ptr, bus.wr_ptr, bus.row_cnt, bus.ptr_valid, bus.dir,
                 bus.first_row, bus.busy, bus.done, bus.cfg_err}, 32'd0);
    endtask

    // mode 0: none, 1: 4-cycle hold at ptr 2, 2: extra start while busy, 3: reset in row 2
    task automatic disturb(input int mode);
        int t;
        t = 0;
        case (mode)
            1: begin
                while (!(bus.ptr_valid && bus.rd_ptr == 9'd2) && t < 100) begin
                    @(posedge clk); #1; t++;
                end
                chk("hold_reach_ptr2", {31'd0, t < 100}, 32'd1);
                bus.hold = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("hold_ptr_valid", {31'd0, bus.ptr_valid}, 32'd0);
                    chk("hold_ptr", 32'(bus.rd_ptr), 32'd2);
                    @(posedge clk); #1;
                end
                bus.hold = 1'b0;
                @(posedge clk); #1;
                chk("resume_ptr", 32'(bus.rd_ptr), 32'd3);
            end
            2: begin
                repeat (5) @(posedge clk);
                #1 bus.col = 9'd3; bus.start = 1'b1;
                @(posedge clk); #1 bus.start = 1'b0;
                @(negedge clk);
                chk("busy_start_err", {31'd0, bus.cfg_err}, 32'd0);
            end
            3: begin
                while (bus.row_cnt != 8'd2 && t < 100) begin
                    @(posedge clk); #1; t++;
                end
                chk("rst_reach_row2", {31'd0, t < 100}, 32'd1);
                #1 rst_n = 1'b0;
                #1 chk_all_zero("midscan_rst_outs");
                q.delete();
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("post_rst_done", {31'd0, bus.done}, 32'd0);
                end
            end
            default: ;
        endcase
    endtask

    task automatic run(input int w, input int exp_busy, input int exp_vld, input int mode);
        int  bcnt, vcnt, t;
        bit  to;
        bcnt = 0; vcnt = 0; t = 0; to = 1'b0;
        @(posedge clk); #1 bus.col = PTR_W'(w); bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        fork
            begin
                while (1) begin
                    @(negedge clk);
                    if (bus.busy) bcnt++;
                    if (bus.ptr_valid) vcnt++;
                    if (!bus.busy && bcnt > 0) break;
                    if (++t > 3000) begin to = 1'b1; break; end
                end
            end
            disturb(mode);
        join
        chk("scan_timeout", {31'd0, to}, 32'd0);
        if (mode != 3) begin
            chk("busy_cycles", bcnt, exp_busy);
            chk("valid_cycles", vcnt, exp_vld);
        end
    endtask

    int exp5_ptr[9] = '{0, 1, 2, 2, 1, 0, 0, 1, 2};

    initial begin
        bus.start = 1'b0;
        bus.col   = '0;
        bus.hold  = 1'b0;
        rst_n     = 1'b0;
        #12 chk_all_zero("reset_outs");
        #10 rst_n = 1'b1;

        for (int i = 0; i < 9; i++) push_v(exp5_ptr[i], i / 3);
        push_k(3'b010);
        run(5, 12, 9, 0);

        push_v(0, 0);
        push_k(3'b010);
        run(3, 2, 1, 0);

        push_k(3'b001);
        @(posedge clk); #1 bus.col = 9'd2; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("cfg_err_busy", {31'd0, bus.busy}, 32'd0);
        end

        gen_scan(6);
        run(6, 24, 16, 1);
`ifdef REUSE_PTR_CTRL_PERF_EN
        chk("stall_cnt", 32'(bus.stall_cnt), 32'd4);
`endif

        gen_scan(8);
        run(8, 42, 36, 2);

        gen_scan(7);
        run(7, 0, 0, 3);
        gen_scan(7);
        run(7, 30, 25, 0);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reuse_ptr_ctrl.md
Name: reuse_ptr_ctrl

Overview:
- Sequencer for the line-reuse register arrays in the CCM.
- Generates a serpentine (boustrophedon) scan over one square feature map for a 3x3 valid convolution:
  - even output rows run left-to-right;
  - odd output rows run right-to-left.
- Drives a shared rd_ptr/wr_ptr pair into two register arrays. The arrays act as a one-row delay line: they read the old contents at an address in the same cycle that new data is written there.
- Flags row turns, first row and completion to the downstream PE/accumulator.

Parameters:
- PTR_W, 9, width of col, rd_ptr and wr_ptr.
- CNT_W, 8, width of the row counter.
- MIN_COL, 3, smallest legal map width; equals the kernel size.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a scan; only honoured in IDLE
- col  in  PTR_W  map width (and height); sampled on an accepted start
- hold  in  1  stall; freezes all state while asserted
- rd_ptr  out  PTR_W  read address to the register arrays
- wr_ptr  out  PTR_W  write address to the register arrays; always equal to rd_ptr
- ptr_valid  out  1  the pointers address a real output position this cycle
- dir  out  1  0 = rightward row, 1 = leftward row
- first_row  out  1  high during row 0; array read data is invalid then
- row_cnt  out  CNT_W  current output row index
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at the end of a scan
- cfg_err  out  1  one-cycle pulse when start is rejected because col < MIN_COL

Behaviour:
- Reset values: every output 0; state = IDLE; latched width w_q = 0.
- Reset mid-scan: abort immediately, return to IDLE with all outputs 0, no done pulse.
- Width arithmetic:
  - positions per row P = w_q - 2; rows R = w_q - 2.
  - last = P - 1, computed in PTR_W bits; no wrap is possible because w_q >= 3.
- IDLE:
  - start with col >= MIN_COL: latch w_q <= col; go to RIGHT; ptrs <= 0, row_cnt <= 0, dir <= 0, first_row <= 1.
  - start with col < MIN_COL: pulse cfg_err; stay in IDLE.
- RIGHT (ptr_valid = 1):
  - ptr != last: ptr <= ptr + 1.
  - ptr == last and row_cnt == R - 1: go to DONE.
  - ptr == last otherwise: go to TURN.
- LEFT (ptr_valid = 1):
  - ptr != 0: ptr <= ptr - 1.
  - ptr == 0 and row_cnt == R - 1: go to DONE.
  - ptr == 0 otherwise: go to TURN.
- TURN (exactly one bubble cycle, ptr_valid = 0):
  - pointers hold.
  - row_cnt <= row_cnt + 1; dir <= ~dir; first_row <= 0.
  - go to LEFT if the new dir = 1, else RIGHT.
- DONE (one cycle): done = 1, busy = 1, ptr_valid = 0; then go to IDLE with ptrs reset to 0.
- Output timing:
  - ptr_valid is the registered valid gated combinationally by ~hold.
  - All other outputs are registered.
  - First valid pointer appears the cycle after start is accepted.
- hold:
  - In RIGHT, LEFT or TURN: all registers freeze and ptr_valid = 0.
  - In IDLE or DONE: hold has no effect; done is never stretched.
- start while busy: ignored; no error.
- Total busy cycles per scan = R*P + (R - 1) + 1.
- Special case col = 3: a single position, then DONE. No TURN occurs.

Optional Feature:
- Macro: REUSE_PTR_CTRL_PERF_EN.
- Enabled:
  - adds output stall_cnt [15:0], counting cycles with busy & hold;
  - saturates at 16'hFFFF;
  - cleared on an accepted start and on reset.
- Disabled: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package reuse_pkg holds:
  - state enum (IDLE = 0, RIGHT = 1, TURN = 2, LEFT = 3, DONE = 4);
  - PTR_W, CNT_W, MIN_COL constants.
- One natural sub-module, reuse_updown_cnt:
  - loadable PTR_W up/down counter with enable;
  - flags at_zero and at_last;
  - instantiated once for the pointer.

Test Plan:
- col = 5, start pulse, hold = 0:
  - ptr sequence 0,1,2 / bubble / 2,1,0 / bubble / 0,1,2;
  - dir sequence 0 / 1 / 0;
  - first_row high for the first 3 valid cycles only;
  - done pulses at cycle 12 after start; busy stays high for 12 cycles.
- col = 3: exactly one ptr_valid cycle with ptr = 0, then a done pulse; busy lasts 2 cycles.
- col = 2 start: cfg_err = 1 for one cycle; busy, ptr_valid and done all stay 0.
- col = 6, hold asserted for 4 cycles mid-row at ptr = 2:
  - ptr_valid = 0 and ptr frozen at 2 during hold;
  - scan resumes at 3 after hold drops;
  - done is delayed by exactly 4 cycles.
- col = 8, second start pulse while busy: ignored; scan finishes normally (ptr_valid count = 36, one done).
- col = 7, rst_n pulled low at row 2: all outputs 0 asynchronously, no done; a fresh start then completes a full scan correctly.
